// File: rtl/pll_reset_seq.sv
// pll_reset_seq: synchronises the PLL lock flag, sequences the core reset and derives phase-aligned clock enables.
// Optional feature macro: PLL_RELOCK_EN (loss of lock in RUN restarts the whole sequence).
module pll_reset_seq #(
    parameter int LOCK_STABLE = 1024,
    parameter int RESET_HOLD  = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pll_locked,
    output logic reset_out,
    output logic ready,
    output logic cen_6,
    output logic cen_6q,
    output logic cen_4
);

    localparam int CNT_MAX = (LOCK_STABLE > RESET_HOLD) ? LOCK_STABLE : RESET_HOLD;
    localparam int CW      = $clog2(CNT_MAX);
    localparam logic [CW-1:0] LOCK_LAST  = CW'(LOCK_STABLE - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(RESET_HOLD - 1);
    localparam logic [5:0]    PHASE_LAST = 6'd47;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RUN       = 2'd2
    } state_t;

    logic          lock_meta_r;
    logic          locked_s_r;
    state_t        state_r;
    state_t        state_nxt_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    logic [5:0]    phase_r;
    logic [5:0]    phase_nxt_s;
    logic          active_s;

    // Two-flop synchroniser for the asynchronous lock flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta_r <= 1'b0;
            locked_s_r  <= 1'b0;
        end else begin
            lock_meta_r <= pll_locked;
            locked_s_r  <= lock_meta_r;
        end
    end

    // Sequencer next-state and shared counter decode.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            WAIT_LOCK: begin
                if (!locked_s_r) begin
                    cnt_nxt_s = '0;
                end else if (cnt_r == LOCK_LAST) begin
                    state_nxt_s = HOLD;
                    cnt_nxt_s   = '0;
                end else begin
                    cnt_nxt_s = cnt_r + CW'(1);
                end
            end
            HOLD: begin
                if (!locked_s_r) begin
                    state_nxt_s = WAIT_LOCK;
                    cnt_nxt_s   = '0;
                end else if (cnt_r == HOLD_LAST) begin
                    state_nxt_s = RUN;
                    cnt_nxt_s   = '0;
                end else begin
                    cnt_nxt_s = cnt_r + CW'(1);
                end
            end
            RUN: begin
`ifdef PLL_RELOCK_EN
                if (!locked_s_r) begin
                    state_nxt_s = WAIT_LOCK;
                    cnt_nxt_s   = '0;
                end else begin
                    cnt_nxt_s = '0;
                end
`else
                cnt_nxt_s = '0;
`endif
            end
            default: begin
                state_nxt_s = WAIT_LOCK;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    // Phase stays at 0 on the edge entering HOLD so the first HOLD cycle carries cen_6/cen_4.
    always_comb begin
        if ((state_r == WAIT_LOCK) || (state_nxt_s == WAIT_LOCK)) begin
            phase_nxt_s = 6'd0;
        end else if (phase_r == PHASE_LAST) begin
            phase_nxt_s = 6'd0;
        end else begin
            phase_nxt_s = phase_r + 6'd1;
        end
    end

    // State, counter, phase and the registered reset/ready outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= WAIT_LOCK;
            cnt_r     <= '0;
            phase_r   <= 6'd0;
            reset_out <= 1'b1;
            ready     <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            phase_r   <= phase_nxt_s;
            reset_out <= (state_nxt_s != RUN);
            ready     <= (state_nxt_s == RUN);
        end
    end

    assign active_s = (state_r != WAIT_LOCK);
    assign cen_6    = active_s && (phase_r[3:0] == 4'd0);
    assign cen_6q   = active_s && (phase_r[3:0] == 4'd4);
    assign cen_4    = active_s && ((phase_r == 6'd0) || (phase_r == 6'd24));

endmodule

// File: tb/tb_pll_reset_seq.sv
// tb_pll_reset_seq: scoreboard bench for pll_reset_seq with a run-length based reference model.
module tb_pll_reset_seq;

    localparam int LS = 8;
    localparam int RH = 4;

    logic clk;
    logic rst_n;
    logic pll_locked;
    logic reset_out;
    logic ready;
    logic cen_6;
    logic cen_6q;
    logic cen_4;

    int n_vec = 0;
    int n_bad = 0;
    logic [4:0] exp_q[$];

    pll_reset_seq #(.LOCK_STABLE(LS), .RESET_HOLD(RH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .reset_out  (reset_out),
        .ready      (ready),
        .cen_6      (cen_6),
        .cen_6q     (cen_6q),
        .cen_4      (cen_4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: outputs follow from the length of the unbroken run of synchronised lock samples.
    initial begin : model
        int  run_len;
        int  edge_n;
        int  hold_edge;
        int  ph;
        int  st;
        bit  s1;
        bit  s2;
        bit  use_s;
        bit  sticky;
        run_len = 0; edge_n = 0; hold_edge = 0; s1 = 1'b0; s2 = 1'b0; sticky = 1'b0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                run_len = 0; s1 = 1'b0; s2 = 1'b0; sticky = 1'b0;
                exp_q.delete();
                exp_q.push_back(5'b10000);
            end else begin
                edge_n++;
                use_s = s2;
                s2 = s1;
                s1 = pll_locked;
                run_len = use_s ? run_len + 1 : 0;
                if (sticky)                  st = 2;
                else if (run_len < LS)       st = 0;
                else if (run_len < LS + RH)  st = 1;
                else                         st = 2;
                if (!sticky && run_len == LS) hold_edge = edge_n;
`ifndef PLL_RELOCK_EN
                if (st == 2) sticky = 1'b1;
`endif
                ph = (edge_n - hold_edge) % 48;
                exp_q.push_back({st != 2, st == 2,
                                 (st != 0) && (ph % 16 == 0),
                                 (st != 0) && (ph % 16 == 4),
                                 (st != 0) && (ph % 24 == 0)});
            end
        end
    end

    // Monitor: every cycle the DUT presents its outputs, compared against the queued expectation.
    initial begin : monitor
        logic [4:0] e;
        logic [4:0] g;
        int cyc;
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            n_vec++;
            g = {reset_out, ready, cen_6, cen_6q, cen_4};
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL cycle %0d scoreboard empty, got %b", cyc, g);
            end else begin
                e = exp_q.pop_front();
                if (g !== e) begin
                    n_bad++;
                    $display("FAIL cycle %0d outputs {reset_out,ready,cen_6,cen_6q,cen_4} got %b expected %b",
                             cyc, g, e);
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic check(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic count_strobes(input int n);
        int c6;
        int c6q;
        int c4;
        int co;
        int qbad;
        int last6;
        c6 = 0; c6q = 0; c4 = 0; co = 0; qbad = 0; last6 = -1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (cen_6) begin
                c6++;
                last6 = i;
            end
            if (cen_6q) begin
                c6q++;
                if (last6 >= 0 && i - last6 != 4) qbad++;
            end
            if (cen_4) c4++;
            if (cen_6 && cen_4) co++;
        end
        check("cen_6 pulses", c6, 30);
        check("cen_6q pulses", c6q, 30);
        check("cen_4 pulses", c4, 20);
        check("cen_6/cen_4 coincidences", co, 10);
        check("cen_6q offset errors", qbad, 0);
        @(posedge clk);
        #2;
    endtask

    initial begin : stimulus
        rst_n = 1'b0;
        pll_locked = 1'b0;
        cycles(3);
        rst_n = 1'b1;
        cycles(100);
        // Short lock pulse, one-cycle dropout, then stable lock.
        pll_locked = 1'b1; cycles(5);
        pll_locked = 1'b0; cycles(1);
        pll_locked = 1'b1; cycles(30);
        count_strobes(480);
        // Lock loss while running, then re-lock.
        pll_locked = 1'b0; cycles(20);
        pll_locked = 1'b1; cycles(30);
        // Full reset, release with lock already high, then a one-cycle reset pulse inside HOLD.
        rst_n = 1'b0; cycles(2);
        rst_n = 1'b1; cycles(11);
        rst_n = 1'b0; cycles(1);
        rst_n = 1'b1; cycles(30);
        // Randomised lock runs and dropouts with occasional reset pulses.
        for (int i = 0; i < 60; i++) begin
            pll_locked = 1'b1;
            cycles(int'($urandom_range(40, 1)));
            pll_locked = 1'b0;
            cycles(int'($urandom_range(4, 1)));
            if ($urandom_range(9, 0) == 0) begin
                rst_n = 1'b0;
                cycles(1);
                rst_n = 1'b1;
            end
        end
        pll_locked = 1'b1;
        cycles(40);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
